// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: control/status bundle between the multicycle FSM and its datapath
interface multicycle_control_unit_if #(
    parameter int RET_W = 32
);
    logic [31:0]      inst;
    logic             mem_ready;
    logic [1:0]       orig_pc;
    logic [1:0]       alu_op;
    logic [1:0]       orig_aula;
    logic [1:0]       orig_bula;
    logic [1:0]       mem_to_reg;
    logic             reg_write;
    logic             write_pc;
    logic             write_pc_cond;
    logic             write_ir;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             mem_err;
    logic [3:0]       state;
    logic [RET_W-1:0] retired;

    modport master (
        input  inst, mem_ready,
        output orig_pc, alu_op, orig_aula, orig_bula, mem_to_reg,
        output reg_write, write_pc, write_pc_cond, write_ir, iord, mem_read, mem_write,
        output mem_err, state, retired
    );

    modport slave (
        output inst, mem_ready,
        input  orig_pc, alu_op, orig_aula, orig_bula, mem_to_reg,
        input  reg_write, write_pc, write_pc_cond, write_ir, iord, mem_read, mem_write,
        input  mem_err, state, retired
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multicycle RISC-V control FSM with memory-ready watchdog and retire counter.
// Define ILLEGAL_TRAP_EN to make the ILLEGAL state absorbing instead of a one-cycle NOP.
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5,
    parameter int RET_W       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    multicycle_control_unit_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        ALU_WB   = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        LUI      = 4'd12,
        AUIPC    = 4'd13,
        ILLEGAL  = 4'd14
    } state_t;

    state_t           state, state_n;
    logic [TO_W-1:0]  wait_cnt;
    logic [RET_W-1:0] retired;
    logic [6:0]       opcode;
    logic             mem_err, waiting, timeout, retire, ready;

    assign opcode  = bus.inst[6:0];
    assign ready   = bus.mem_ready;
    assign waiting = state inside {FETCH, MEM_RD, MEM_WR};
    // the abort fires on the cycle the count would reach MEM_TIMEOUT; ready in that cycle still wins
    assign timeout = waiting && !ready && wait_cnt == TO_W'(MEM_TIMEOUT - 1);

    assign bus.state   = state;
    assign bus.retired = retired;
    assign bus.mem_err = mem_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            wait_cnt <= '0;
            retired  <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= (waiting && state_n == state && !timeout) ? wait_cnt + TO_W'(1) : '0;
            retired  <= retired + RET_W'(retire);
            mem_err  <= timeout;
        end
    end

    always_comb begin
        state_n           = state;
        retire            = 1'b0;
        bus.orig_pc       = 2'b00;
        bus.alu_op        = 2'b00;
        bus.orig_aula     = 2'b00;
        bus.orig_bula     = 2'b00;
        bus.mem_to_reg    = 2'b00;
        bus.reg_write     = 1'b0;
        bus.write_pc      = 1'b0;
        bus.write_pc_cond = 1'b0;
        bus.write_ir      = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        case (state)
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.orig_bula = 2'b01;
                bus.write_ir  = ready;
                bus.write_pc  = ready;
                state_n       = ready ? DECODE : FETCH;
            end
            DECODE: begin
                bus.orig_aula = 2'b10;
                bus.orig_bula = 2'b10;
                case (opcode)
                    7'b0110011:             state_n = EXEC_R;
                    7'b0010011:             state_n = EXEC_I;
                    7'b0000011, 7'b0100011: state_n = MEM_ADDR;
                    7'b1100011:             state_n = BRANCH;
                    7'b1101111:             state_n = JAL;
                    7'b1100111:             state_n = JALR;
                    7'b0110111:             state_n = LUI;
                    7'b0010111:             state_n = AUIPC;
                    default:                state_n = ILLEGAL;
                endcase
            end
            MEM_ADDR: begin
                bus.orig_aula = 2'b01;
                bus.orig_bula = 2'b10;
                state_n       = opcode[5] ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                bus.iord     = 1'b1;
                bus.mem_read = 1'b1;
                state_n      = ready ? MEM_WB : timeout ? FETCH : MEM_RD;
            end
            MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 2'b10;
                retire         = 1'b1;
                state_n        = FETCH;
            end
            MEM_WR: begin
                bus.iord      = 1'b1;
                bus.mem_write = 1'b1;
                retire        = ready;
                state_n       = (ready || timeout) ? FETCH : MEM_WR;
            end
            EXEC_R: begin
                bus.orig_aula = 2'b01;
                bus.alu_op    = 2'b10;
                state_n       = ALU_WB;
            end
            EXEC_I: begin
                bus.orig_aula = 2'b01;
                bus.orig_bula = 2'b10;
                bus.alu_op    = 2'b10;
                state_n       = ALU_WB;
            end
            ALU_WB, AUIPC: begin
                bus.reg_write = 1'b1;
                retire        = 1'b1;
                state_n       = FETCH;
            end
            BRANCH: begin
                bus.orig_aula     = 2'b01;
                bus.alu_op        = 2'b01;
                bus.write_pc_cond = 1'b1;
                bus.orig_pc       = 2'b01;
                retire            = 1'b1;
                state_n           = FETCH;
            end
            JAL: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 2'b01;
                bus.write_pc   = 1'b1;
                bus.orig_pc    = 2'b01;
                retire         = 1'b1;
                state_n        = FETCH;
            end
            JALR: begin
                bus.orig_aula  = 2'b01;
                bus.orig_bula  = 2'b10;
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 2'b01;
                bus.write_pc   = 1'b1;
                bus.orig_pc    = 2'b10;
                retire         = 1'b1;
                state_n        = FETCH;
            end
            LUI: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 2'b11;
                retire         = 1'b1;
                state_n        = FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            ILLEGAL: state_n = ILLEGAL;
`else
            ILLEGAL: begin
                retire  = 1'b1;
                state_n = FETCH;
            end
`endif
            default: state_n = FETCH;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: directed checks of the control FSM with MEM_TIMEOUT=4 and RET_W=4
module tb_multicycle_control_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_ret = 0;

    multicycle_control_unit_if #(.RET_W(4)) bus ();

    multicycle_control_unit #(.MEM_TIMEOUT(4), .TO_W(3), .RET_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.inst      = 32'h0;
        bus.mem_ready = 1'b0;
        rst           = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        vectors++;
        if ({bus.state, bus.retired, bus.mem_err, bus.mem_read, bus.mem_write, bus.write_ir} !== {4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset: got st=%0d ret=%0d err=%b rd=%b wr=%b ir=%b required st=0 ret=0 err=0 rd=1 wr=0 ir=0",
                     bus.state, bus.retired, bus.mem_err, bus.mem_read, bus.mem_write, bus.write_ir);
        end
        exp_ret = 0;
    endtask

    task automatic test_r_type();
        logic [3:0] es [5] = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
        bus.inst      = 32'h002081B3;
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            vectors++;
            if (bus.state !== es[k]) begin
                miscompares++;
                $display("FAIL r_state[%0d]: got %0d required %0d", k, bus.state, es[k]);
            end
            vectors++;
            if (bus.reg_write !== (k == 3)) begin
                miscompares++;
                $display("FAIL r_regwrite[%0d]: got %b required %b", k, bus.reg_write, k == 3);
            end
            if (k == 0) begin
                vectors++;
                if ({bus.write_ir, bus.write_pc, bus.orig_pc, bus.orig_bula} !== {1'b1, 1'b1, 2'b00, 2'b01}) begin
                    miscompares++;
                    $display("FAIL fetch_ready: got ir=%b pc=%b opc=%b bula=%b required 1 1 00 01",
                             bus.write_ir, bus.write_pc, bus.orig_pc, bus.orig_bula);
                end
            end
            if (k == 2) begin
                vectors++;
                if ({bus.alu_op, bus.orig_aula, bus.orig_bula} !== 6'b10_01_00) begin
                    miscompares++;
                    $display("FAIL exec_r_sel: got %b required 100100", {bus.alu_op, bus.orig_aula, bus.orig_bula});
                end
            end
            if (k < 4) tick();
        end
        exp_ret++;
        vectors++;
        if (bus.retired !== 4'(exp_ret)) begin
            miscompares++;
            $display("FAIL r_retired: got %0d required %0d", bus.retired, 4'(exp_ret));
        end
    endtask

    task automatic test_load_wait();
        bus.inst      = 32'h0000A183;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        vectors++;
        if (bus.state !== 4'd2) begin
            miscompares++;
            $display("FAIL lw_addr: got %0d required 2", bus.state);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            bus.mem_ready = (k == 3);
            #1;
            vectors++;
            if ({bus.state, bus.mem_read, bus.iord, bus.mem_err} !== {4'd3, 1'b1, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL lw_wait[%0d]: got st=%0d rd=%b iord=%b err=%b required st=3 rd=1 iord=1 err=0",
                         k, bus.state, bus.mem_read, bus.iord, bus.mem_err);
            end
            tick();
        end
        vectors++;
        if ({bus.state, bus.mem_to_reg, bus.reg_write, bus.retired} !== {4'd4, 2'b10, 1'b1, 4'(exp_ret)}) begin
            miscompares++;
            $display("FAIL lw_wb: got st=%0d m2r=%b rw=%b ret=%0d required st=4 m2r=10 rw=1 ret=%0d",
                     bus.state, bus.mem_to_reg, bus.reg_write, bus.retired, 4'(exp_ret));
        end
        tick();
        exp_ret++;
        vectors++;
        if ({bus.state, bus.retired} !== {4'd0, 4'(exp_ret)}) begin
            miscompares++;
            $display("FAIL lw_done: got st=%0d ret=%0d required st=0 ret=%0d", bus.state, bus.retired, 4'(exp_ret));
        end
    endtask

    task automatic test_store_timeout();
        bus.inst      = 32'h0020A023;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            bus.mem_ready = 1'b0;
            #1;
            vectors++;
            if ({bus.state, bus.mem_write, bus.iord, bus.mem_err} !== {4'd5, 1'b1, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL sw_wait[%0d]: got st=%0d wr=%b iord=%b err=%b required st=5 wr=1 iord=1 err=0",
                         k, bus.state, bus.mem_write, bus.iord, bus.mem_err);
            end
            tick();
        end
        vectors++;
        if ({bus.state, bus.mem_err, bus.retired, bus.write_ir, bus.write_pc} !== {4'd0, 1'b1, 4'(exp_ret), 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL sw_timeout: got st=%0d err=%b ret=%0d ir=%b pc=%b required st=0 err=1 ret=%0d ir=0 pc=0",
                     bus.state, bus.mem_err, bus.retired, bus.write_ir, bus.write_pc, 4'(exp_ret));
        end
        bus.mem_ready = 1'b1;
        tick();
        vectors++;
        if ({bus.state, bus.mem_err} !== {4'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL sw_err_pulse: got st=%0d err=%b required st=1 err=0", bus.state, bus.mem_err);
        end
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            bus.mem_ready = (k == 3);
            #1;
            vectors++;
            if ({bus.state, bus.mem_err} !== {4'd5, 1'b0}) begin
                miscompares++;
                $display("FAIL sw_late[%0d]: got st=%0d err=%b required st=5 err=0", k, bus.state, bus.mem_err);
            end
            tick();
        end
        exp_ret++;
        vectors++;
        if ({bus.state, bus.mem_err, bus.retired} !== {4'd0, 1'b0, 4'(exp_ret)}) begin
            miscompares++;
            $display("FAIL sw_ready_wins: got st=%0d err=%b ret=%0d required st=0 err=0 ret=%0d",
                     bus.state, bus.mem_err, bus.retired, 4'(exp_ret));
        end
    endtask

    task automatic test_jumps();
        bus.inst      = 32'h000080E7;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        vectors++;
        if ({bus.state, bus.orig_pc, bus.mem_to_reg, bus.write_pc, bus.reg_write, bus.orig_aula, bus.orig_bula}
            !== {4'd11, 2'b10, 2'b01, 1'b1, 1'b1, 2'b01, 2'b10}) begin
            miscompares++;
            $display("FAIL jalr: got st=%0d opc=%b m2r=%b wpc=%b rw=%b a=%b b=%b required st=11 opc=10 m2r=01 wpc=1 rw=1 a=01 b=10",
                     bus.state, bus.orig_pc, bus.mem_to_reg, bus.write_pc, bus.reg_write, bus.orig_aula, bus.orig_bula);
        end
        bus.inst = 32'h123450B7;
        tick();
        tick();
        tick();
        vectors++;
        if ({bus.state, bus.mem_to_reg, bus.reg_write, bus.write_pc} !== {4'd12, 2'b11, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL lui: got st=%0d m2r=%b rw=%b wpc=%b required st=12 m2r=11 rw=1 wpc=0",
                     bus.state, bus.mem_to_reg, bus.reg_write, bus.write_pc);
        end
        bus.inst = 32'h00208463;
        tick();
        tick();
        tick();
        vectors++;
        if ({bus.state, bus.alu_op, bus.write_pc_cond, bus.orig_pc, bus.orig_aula, bus.orig_bula, bus.reg_write}
            !== {4'd9, 2'b01, 1'b1, 2'b01, 2'b01, 2'b00, 1'b0}) begin
            miscompares++;
            $display("FAIL branch: got st=%0d op=%b pcc=%b opc=%b a=%b b=%b rw=%b required st=9 op=01 pcc=1 opc=01 a=01 b=00 rw=0",
                     bus.state, bus.alu_op, bus.write_pc_cond, bus.orig_pc, bus.orig_aula, bus.orig_bula, bus.reg_write);
        end
        tick();
        exp_ret += 3;
        vectors++;
        if ({bus.state, bus.retired} !== {4'd0, 4'(exp_ret)}) begin
            miscompares++;
            $display("FAIL jumps_retired: got st=%0d ret=%0d required st=0 ret=%0d", bus.state, bus.retired, 4'(exp_ret));
        end
    endtask

    task automatic test_illegal();
        bus.inst      = 32'h0000007F;
        bus.mem_ready = 1'b1;
        tick();
        tick();
`ifdef ILLEGAL_TRAP_EN
        for (int k = 0; k < 20; k++) begin
            vectors++;
            if ({bus.state, bus.reg_write, bus.write_pc, bus.write_pc_cond, bus.write_ir, bus.mem_read, bus.mem_write}
                !== {4'd14, 6'b0}) begin
                miscompares++;
                $display("FAIL illegal_trap[%0d]: got st=%0d en=%b required st=14 en=000000", k, bus.state,
                         {bus.reg_write, bus.write_pc, bus.write_pc_cond, bus.write_ir, bus.mem_read, bus.mem_write});
            end
            tick();
        end
        vectors++;
        if (bus.retired !== 4'(exp_ret)) begin
            miscompares++;
            $display("FAIL illegal_trap_ret: got %0d required %0d", bus.retired, 4'(exp_ret));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_ret = 0;
        vectors++;
        if ({bus.state, bus.retired} !== {4'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL illegal_exit: got st=%0d ret=%0d required st=0 ret=0", bus.state, bus.retired);
        end
`else
        vectors++;
        if ({bus.state, bus.reg_write, bus.write_pc, bus.write_pc_cond, bus.write_ir, bus.mem_read, bus.mem_write}
            !== {4'd14, 6'b0}) begin
            miscompares++;
            $display("FAIL illegal_nop: got st=%0d en=%b required st=14 en=000000", bus.state,
                     {bus.reg_write, bus.write_pc, bus.write_pc_cond, bus.write_ir, bus.mem_read, bus.mem_write});
        end
        tick();
        exp_ret++;
        vectors++;
        if ({bus.state, bus.retired} !== {4'd0, 4'(exp_ret)}) begin
            miscompares++;
            $display("FAIL illegal_exit: got st=%0d ret=%0d required st=0 ret=%0d", bus.state, bus.retired, 4'(exp_ret));
        end
`endif
    endtask

    task automatic test_reset_mid_wait();
        bus.inst      = 32'h0000A183;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        tick();
        bus.mem_ready = 1'b0;
        tick();
        tick();
        vectors++;
        if (bus.state !== 4'd3) begin
            miscompares++;
            $display("FAIL pre_reset: got st=%0d required 3", bus.state);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_ret = 0;
        vectors++;
        if ({bus.state, bus.retired, bus.mem_err, bus.mem_read, bus.iord, bus.mem_write} !== {4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL mid_reset: got st=%0d ret=%0d err=%b rd=%b iord=%b wr=%b required st=0 ret=0 err=0 rd=1 iord=0 wr=0",
                     bus.state, bus.retired, bus.mem_err, bus.mem_read, bus.iord, bus.mem_write);
        end
        for (int k = 0; k < 4; k++) begin
            #1;
            vectors++;
            if ({bus.state, bus.mem_err, bus.write_ir} !== {4'd0, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL fetch_wait[%0d]: got st=%0d err=%b ir=%b required st=0 err=0 ir=0", k, bus.state, bus.mem_err, bus.write_ir);
            end
            tick();
        end
        vectors++;
        if ({bus.state, bus.mem_err, bus.retired} !== {4'd0, 1'b1, 4'd0}) begin
            miscompares++;
            $display("FAIL fetch_timeout: got st=%0d err=%b ret=%0d required st=0 err=1 ret=0", bus.state, bus.mem_err, bus.retired);
        end
    endtask

    task automatic test_wrap();
        bus.inst      = 32'h002081B3;
        bus.mem_ready = 1'b1;
        for (int n = 0; n < 17; n++) begin
            tick();
            tick();
            tick();
            tick();
        end
        exp_ret += 17;
        vectors++;
        if ({bus.state, bus.retired} !== {4'd0, 4'(exp_ret)}) begin
            miscompares++;
            $display("FAIL retire_wrap: got st=%0d ret=%0d required st=0 ret=%0d", bus.state, bus.retired, 4'(exp_ret));
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_load_wait();
        test_store_timeout();
        test_jumps();
        test_illegal();
        test_reset_mid_wait();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
